// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file operand-fetch stage.
// Imported by the fetch top and its per-operand forwarding mux.
package regfile_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    VALID
  } fetch_state_e;

  function automatic logic is_x0(
    input logic [RF_ADDR_W-1:0] addr
  );
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One operand slot: forward flag, x0 zeroing, capture register,
// and writeback tracking while the operand is held.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              capture,
  input  logic              hold,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  logic              wb_hit;
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] cap_val;
  logic [DATA_W-1:0] data_q;

  assign wb_hit = wr_en && (wr_addr == idx);
  assign data   = data_q;

  // Capture value: the newest source wins (same-edge wb, then
  // issue-edge forward, then the memory's pre-write read data).
  always_comb begin
    cap_val = rd_data;
    if (is_x0(idx)) begin
      cap_val = '0;
    end else if (wb_hit) begin
      cap_val = wr_data;
    end else if (fwd_q) begin
      cap_val = fwd_data_q;
    end
  end

  // Forward flag: remember a write that raced the read at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (issue) begin
      fwd_q      <= wb_hit;
      fwd_data_q <= wr_data;
    end
  end

  // Operand register: capture once, then follow later writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= cap_val;
    end else if (hold && wb_hit) begin
      data_q <= wr_data;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch in front of a 1-cycle buffered register memory:
// read issue, x0 rule, wb forwarding and valid/ready to execute.
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_rs1,
  input  logic [ADDR_W-1:0]            req_rs2,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [DATA_W-1:0]            op_rs1_data,
  output logic [DATA_W-1:0]            op_rs2_data,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  output logic [READ_PORTS-1:0]        mem_rd_en,
  output logic [READ_PORTS*ADDR_W-1:0] mem_rd_addr,
  input  logic [READ_PORTS*DATA_W-1:0] mem_rd_data,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_W-1:0]            mem_wr_data
);

  localparam bit SERIAL = (READ_PORTS == 1);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic              accept;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rs1_idx;
  logic [ADDR_W-1:0] rs2_idx;
  logic              iss1;
  logic              iss2;
  logic              cap1;
  logic              cap2;
  logic              hold1;
  logic              hold2;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  // x0 is never written; the memory itself does not know that.
  assign mem_wr_en   = wb_en && !is_x0(wb_addr);
  assign mem_wr_addr = wb_addr;
  assign mem_wr_data = wb_data;

  assign op_valid = (state == VALID);

  // Issue index comes straight from decode in the accept cycle.
  assign rs1_idx = accept ? req_rs1 : rs1_q;
  assign rs2_idx = accept ? req_rs2 : rs2_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = RD1;
      end
      RD1: begin
        state_nxt = SERIAL ? RD2 : VALID;
      end
      RD2: begin
        state_nxt = VALID;
      end
      VALID: begin
        if (accept) begin
          state_nxt = RD1;
        end else if (op_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and per-operand strobes.
  always_comb begin
    req_ready = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    hold1     = 1'b0;
    hold2     = 1'b0;
    iss2      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      RD1: begin
        cap1 = 1'b1;
        cap2 = !SERIAL;
        iss2 = SERIAL;
      end
      RD2: begin
        cap2  = 1'b1;
        hold1 = 1'b1;
      end
      VALID: begin
        req_ready = op_ready;
        hold1     = 1'b1;
        hold2     = 1'b1;
      end
      default: ;
    endcase
    accept = req_valid && req_ready && rst_n;
    iss1   = accept;
    if (!SERIAL) iss2 = accept;
    if (accept) begin
      hold1 = 1'b0;
      hold2 = 1'b0;
    end
  end

  // Indices latched at accept for later issue and capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      rs1_q <= req_rs1;
      rs2_q <= req_rs2;
    end
  end

  generate
    if (SERIAL) begin : g_serial
      assign mem_rd_en   = accept || (state == RD1);
      assign mem_rd_addr = accept ? req_rs1 : rs2_q;
      assign rd_data0    = mem_rd_data[DATA_W-1:0];
      assign rd_data1    = mem_rd_data[DATA_W-1:0];
    end else begin : g_dual
      assign mem_rd_en   = {accept, accept};
      assign mem_rd_addr = {req_rs2, req_rs1};
      assign rd_data0    = mem_rd_data[DATA_W-1:0];
      assign rd_data1    = mem_rd_data[2*DATA_W-1:DATA_W];
    end
  endgenerate

  regfile_fwd_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_rs1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (iss1),
    .capture (cap1),
    .hold    (hold1),
    .idx     (rs1_idx),
    .rd_data (rd_data0),
    .wr_en   (mem_wr_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .data    (op_rs1_data)
  );

  regfile_fwd_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_rs2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (iss2),
    .capture (cap2),
    .hold    (hold2),
    .idx     (rs2_idx),
    .rd_data (rd_data1),
    .wr_en   (mem_wr_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .data    (op_rs2_data)
  );

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: dual-port and serial instances,
// each with a buffered-read memory, checked against a register model.
module tb_regfile_operand_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ser;
  logic        req_valid;
  logic        op_ready;
  logic [3:0]  req_rs1;
  logic [3:0]  req_rs2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  logic        req_valid_p, req_ready_p, op_valid_p, op_ready_p;
  logic [31:0] op1_p, op2_p;
  logic [1:0]  rd_en_p;
  logic [7:0]  rd_addr_p;
  logic [63:0] rd_data_p;
  logic        wr_en_p;
  logic [3:0]  wr_addr_p;
  logic [31:0] wr_data_p;

  logic        req_valid_s, req_ready_s, op_valid_s, op_ready_s;
  logic [31:0] op1_s, op2_s;
  logic [0:0]  rd_en_s;
  logic [3:0]  rd_addr_s;
  logic [31:0] rd_data_s;
  logic        wr_en_s;
  logic [3:0]  wr_addr_s;
  logic [31:0] wr_data_s;

  assign req_valid_p = req_valid && !ser;
  assign op_ready_p  = ser ? 1'b1 : op_ready;
  assign req_valid_s = req_valid && ser;
  assign op_ready_s  = ser ? op_ready : 1'b1;

  logic        req_ready_m, op_valid_m;
  logic [31:0] op1_m, op2_m;
  assign req_ready_m = ser ? req_ready_s : req_ready_p;
  assign op_valid_m  = ser ? op_valid_s : op_valid_p;
  assign op1_m       = ser ? op1_s : op1_p;
  assign op2_m       = ser ? op2_s : op2_p;

  regfile_operand_fetch #(.READ_PORTS(2)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_p), .req_ready(req_ready_p),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid_p), .op_ready(op_ready_p),
    .op_rs1_data(op1_p), .op_rs2_data(op2_p),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_rd_en(rd_en_p), .mem_rd_addr(rd_addr_p),
    .mem_rd_data(rd_data_p),
    .mem_wr_en(wr_en_p), .mem_wr_addr(wr_addr_p),
    .mem_wr_data(wr_data_p)
  );

  regfile_operand_fetch #(.READ_PORTS(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid_s), .op_ready(op_ready_s),
    .op_rs1_data(op1_s), .op_rs2_data(op2_s),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_rd_en(rd_en_s), .mem_rd_addr(rd_addr_s),
    .mem_rd_data(rd_data_s),
    .mem_wr_en(wr_en_s), .mem_wr_addr(wr_addr_s),
    .mem_wr_data(wr_data_s)
  );

  // Register memories: buffered reads return the pre-write value.
  logic [31:0] mem_p [16];
  logic [31:0] mem_s [16];
  always @(posedge clk) begin
    if (wr_en_p) mem_p[wr_addr_p] <= wr_data_p;
    if (rd_en_p[0]) rd_data_p[31:0] <= mem_p[rd_addr_p[3:0]];
    if (rd_en_p[1]) rd_data_p[63:32] <= mem_p[rd_addr_p[7:4]];
    if (wr_en_s) mem_s[wr_addr_s] <= wr_data_s;
    if (rd_en_s[0]) rd_data_s <= mem_s[rd_addr_s];
  end

  // Architectural register file: x0 reads as zero, writes to it vanish.
  logic [31:0] ref_rf [16];
  always @(posedge clk) begin
    if (wb_en && wb_addr != 4'd0) ref_rf[wb_addr] <= wb_data;
  end

  function automatic logic [31:0] refv(input logic [3:0] a);
    return (a == 4'd0) ? 32'h0 : ref_rf[a];
  endfunction

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] rs1;
    logic [3:0] rs2;
    int         t;
  } req_t;

  req_t q[$];
  int   cyc = 0;
  bit   acc_m, v_pos, v_neg;

  // Operands are valid once the fetch latency has elapsed.
  function automatic bit exp_valid();
    int lat;
    lat = ser ? 2 : 1;
    return q.size() > 0 && (cyc - q[0].t) > lat;
  endfunction

  // Transaction model: accepts and consumes on rising edges.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      v_pos = exp_valid();
      acc_m = req_valid && (q.size() == 0 || (v_pos && op_ready));
      if (v_pos && op_ready) void'(q.pop_front());
      if (acc_m) q.push_back('{req_rs1, req_rs2, cyc});
    end
    cyc++;
  end

  // Continuous comparison on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      v_neg = exp_valid();
      chk("op_valid", 32'(op_valid_m), 32'(v_neg));
      chk("req_ready", 32'(req_ready_m),
          32'(q.size() == 0 || (v_neg && op_ready)));
      chk("wr_gate_p", 32'(wr_en_p),
          32'(wb_en && wb_addr != 4'd0));
      chk("wr_gate_s", 32'(wr_en_s),
          32'(wb_en && wb_addr != 4'd0));
      if (v_neg) begin
        chk("op1", op1_m, refv(q[0].rs1));
        chk("op2", op2_m, refv(q[0].rs2));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b);
    req_valid = 1'b1;
    req_rs1   = a;
    req_rs2   = b;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    op_ready  = 1'b1;
    wb_en     = 1'b0;
    repeat (4) step();
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_rs1   = $urandom_range(0, 1) != 0 ?
                  4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      req_rs2   = $urandom_range(0, 1) != 0 ?
                  4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      op_ready  = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_addr   = $urandom_range(0, 1) != 0 ?
                  4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wb_data   = $urandom;
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ser       = 1'b0;
    req_valid = 1'b0;
    op_ready  = 1'b1;
    req_rs1   = '0;
    req_rs2   = '0;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    repeat (2) step();
    chk("rst_valid_p", 32'(op_valid_p), 32'd0);
    chk("rst_valid_s", 32'(op_valid_s), 32'd0);
    chk("rst_ready_p", 32'(req_ready_p), 32'd1);
    chk("rst_ready_s", 32'(req_ready_s), 32'd1);
    chk("rst_op1_p", op1_p, 32'h0);
    chk("rst_op2_p", op2_p, 32'h0);
    chk("rst_rden_p", 32'(rd_en_p), 32'd0);
    chk("rst_rden_s", 32'(rd_en_s), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i < 16; i++) begin
      wb(4'(i), $urandom);
      step();
    end
    wb_en = 1'b0;

    // basic dual-port fetch
    wb(4'd5, 32'hDEADBEEF);
    step();
    wb_en = 1'b0;
    req(4'd5, 4'd0);
    step();
    req_valid = 1'b0;
    step();
    chk("basic_valid", 32'(op_valid_p), 32'd1);
    chk("basic_op1", op1_p, 32'hDEADBEEF);
    chk("basic_op2", op2_p, 32'h0);
    step();

    // x0 write is dropped
    wb(4'd0, 32'h1234);
    #1;
    chk("x0_wr_en", 32'(wr_en_p), 32'd0);
    step();
    wb_en = 1'b0;
    req(4'd0, 4'd5);
    step();
    req_valid = 1'b0;
    step();
    chk("x0_op1", op1_p, 32'h0);
    step();

    // write on the accept edge
    wb(4'd3, 32'h11);
    step();
    wb(4'd3, 32'h22);
    req(4'd3, 4'd3);
    step();
    wb_en     = 1'b0;
    req_valid = 1'b0;
    step();
    chk("hazard_op1", op1_p, 32'h22);
    chk("hazard_op2", op2_p, 32'h22);
    step();

    // backpressure with a write to a held operand
    wb(4'd7, 32'h1);
    step();
    wb_en    = 1'b0;
    op_ready = 1'b0;
    req(4'd1, 4'd7);
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wb(4'd7, 32'h99);
      step();
      wb_en = 1'b0;
      chk("bp_valid", 32'(op_valid_p), 32'd1);
      chk("bp_ready", 32'(req_ready_p), 32'd0);
    end
    chk("bp_op2", op2_p, 32'h99);
    op_ready = 1'b1;
    step();

    rand_run(300);
    drain();
    ser = 1'b1;

    // serial fetch through port 0
    wb(4'd1, 32'hA);
    step();
    wb(4'd2, 32'hB);
    step();
    wb_en = 1'b0;
    req(4'd1, 4'd2);
    #1;
    chk("ser_en0", 32'(rd_en_s), 32'd1);
    chk("ser_addr0", 32'(rd_addr_s), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    chk("ser_en1", 32'(rd_en_s), 32'd1);
    chk("ser_addr1", 32'(rd_addr_s), 32'd2);
    step();
    chk("ser_en2", 32'(rd_en_s), 32'd0);
    chk("ser_wait", 32'(op_valid_s), 32'd0);
    step();
    chk("ser_valid", 32'(op_valid_s), 32'd1);
    chk("ser_op1", op1_s, 32'hA);
    chk("ser_op2", op2_s, 32'hB);
    step();

    // reset while in RD2
    req(4'd1, 4'd2);
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(op_valid_s), 32'd0);
    chk("mid_rst_ready", 32'(req_ready_s), 32'd1);
    step();
    rst_n = 1'b1;
    req(4'd2, 4'd1);
    step();
    req_valid = 1'b0;
    repeat (2) step();
    chk("post_rst_valid", 32'(op_valid_s), 32'd1);
    chk("post_rst_op1", op1_s, 32'hB);
    chk("post_rst_op2", op2_s, 32'hA);
    step();

    rand_run(300);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
